// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl
// Hazard and forwarding controller for the pipelined OTTER core.
// Chooses EX operand forwarding sources, inserts multi-cycle load-use bubbles through an
// internal stall counter, raises flush on a PC redirect, and keeps saturating stall and
// flush event counters. FWD_EN=0 gives a stall-only build in which every RAW hazard
// between ID and a later stage is resolved by stalling.
//
// Ports:
//   CLK, RST                   clock, synchronous active-high reset
//   rs1_d/rs2_d, rs*_used_d    ID source registers and their use flags
//   rs1_e/rs2_e, rs*_used_e    EX source registers and their use flags
//   rd_e, reg_write_e,
//   mem_read_e                 EX destination, write enable, load flag
//   rd_m/reg_write_m           EX/MEM destination and write enable
//   rd_w/reg_write_w           MEM/WB destination and write enable
//   pc_source                  PC select from EX, nonzero = redirect
//   cnt_clr                    synchronous clear of the event counters
//   fwd_a/fwd_b                00 = regfile, 10 = EX/MEM, 01 = MEM/WB
//   stall, flush               pipeline control
//   stall_count, flush_count   saturating event counters
module otter_hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic              rs1_used_d,
  input  logic              rs2_used_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic              rs1_used_e,
  input  logic              rs2_used_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              reg_write_e,
  input  logic              mem_read_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  input  logic [2:0]        pc_source,
  input  logic              cnt_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall,
  output logic              flush,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned SCNT_W = $clog2(8);
  // Counter reload values are "cycles - 1": the detect cycle itself is the first bubble.
  localparam logic [SCNT_W-1:0] LoadLen = SCNT_W'(LOAD_LAT - 1);
  localparam logic [SCNT_W-1:0] ExLen   = SCNT_W'(2);
  localparam logic [SCNT_W-1:0] MemLen  = SCNT_W'(1);
  localparam logic [SCNT_W-1:0] WbLen   = SCNT_W'(0);

  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0]  stall_count_q, flush_count_q;

  logic              ex_hit, m_hit, w_hit, load_use;
  logic              detect, detect_q, flush_raw;
  logic [SCNT_W-1:0] len;

  // ID-stage RAW match against a writing destination; x0 never matches.
  function automatic logic id_match(input logic [REG_AW-1:0] rd, input logic we,
                                    input logic [REG_AW-1:0] s1, input logic u1,
                                    input logic [REG_AW-1:0] s2, input logic u2);
    return we && (rd != '0) && ((u1 && (s1 == rd)) || (u2 && (s2 == rd)));
  endfunction

  // EX operand source select; EX/MEM wins over MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic used,
                                         input logic [REG_AW-1:0] rdm, input logic wem,
                                         input logic [REG_AW-1:0] rdw, input logic wew);
    if (used && wem && (rdm != '0) && (rs == rdm)) begin
      return 2'b10;
    end else if (used && wew && (rdw != '0) && (rs == rdw)) begin
      return 2'b01;
    end
    return 2'b00;
  endfunction

  always_comb begin
    ex_hit   = id_match(rd_e, reg_write_e, rs1_d, rs1_used_d, rs2_d, rs2_used_d);
    m_hit    = id_match(rd_m, reg_write_m, rs1_d, rs1_used_d, rs2_d, rs2_used_d);
    w_hit    = id_match(rd_w, reg_write_w, rs1_d, rs1_used_d, rs2_d, rs2_used_d);
    load_use = mem_read_e && ex_hit;

    detect = load_use;
    len    = LoadLen;
    if (FWD_EN == 0) begin
      // Without forwarding the bubble must cover the producer's distance to writeback;
      // the closest producer dictates the longest wait.
      detect = load_use || ex_hit || m_hit || w_hit;
      len    = WbLen;
      if (m_hit)  len = MemLen;
      if (ex_hit) len = ExLen;
      if (load_use && (LoadLen > len)) len = LoadLen;
    end
  end

  always_comb begin
    flush_raw = (pc_source != 3'b000);
    detect_q  = detect && (scnt_q == '0);

    flush = !RST && flush_raw;
    stall = !RST && !flush_raw && (detect_q || (scnt_q != '0));

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if ((FWD_EN != 0) && !RST) begin
      fwd_a = fwd_sel(rs1_e, rs1_used_e, rd_m, reg_write_m, rd_w, reg_write_w);
      fwd_b = fwd_sel(rs2_e, rs2_used_e, rd_m, reg_write_m, rd_w, reg_write_w);
    end

    scnt_d = scnt_q;
    if (flush_raw) begin
      scnt_d = '0;
    end else if (detect_q) begin
      scnt_d = len;
    end else if (scnt_q != '0) begin
      scnt_d = scnt_q - SCNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      scnt_q        <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      if (cnt_clr) begin
        stall_count_q <= '0;
        flush_count_q <= '0;
      end else begin
        if (stall && (stall_count_q != '1)) stall_count_q <= stall_count_q + CNT_W'(1);
        if (flush && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_otter_hazard_ctrl.sv
// Scoreboard bench for otter_hazard_ctrl. Three instances share one stimulus stream:
//   inst 0: LOAD_LAT=1, forwarding, CNT_W=16
//   inst 1: LOAD_LAT=3, forwarding, CNT_W=4
//   inst 2: LOAD_LAT=1, stall-only, CNT_W=16
// Stimulus pushes expected values tagged with the cycle index; a negedge monitor pops
// and compares them.
module tb_otter_hazard_ctrl;

  localparam int F_FWDA = 0, F_FWDB = 1, F_STALL = 2, F_FLUSH = 3, F_SCNT = 4, F_FCNT = 5;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       rs1_used_d, rs2_used_d, rs1_used_e, rs2_used_e;
  logic       reg_write_e, mem_read_e, reg_write_m, reg_write_w, cnt_clr;
  logic [2:0] pc_source;

  logic [1:0]  fwd_a0, fwd_b0, fwd_a1, fwd_b1, fwd_a2, fwd_b2;
  logic        stall0, flush0, stall1, flush1, stall2, flush2;
  logic [15:0] scnt0, fcnt0, scnt2, fcnt2;
  logic [3:0]  scnt1, fcnt1;

  otter_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .FWD_EN(1), .CNT_W(16)) u_l1 (
    .CLK(CLK), .RST(RST), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_used_e(rs1_used_e),
    .rs2_used_e(rs2_used_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .pc_source(pc_source), .cnt_clr(cnt_clr),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0), .stall(stall0), .flush(flush0),
    .stall_count(scnt0), .flush_count(fcnt0));

  otter_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .FWD_EN(1), .CNT_W(4)) u_l3 (
    .CLK(CLK), .RST(RST), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_used_e(rs1_used_e),
    .rs2_used_e(rs2_used_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .pc_source(pc_source), .cnt_clr(cnt_clr),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall(stall1), .flush(flush1),
    .stall_count(scnt1), .flush_count(fcnt1));

  otter_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .FWD_EN(0), .CNT_W(16)) u_nf (
    .CLK(CLK), .RST(RST), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1_used_e(rs1_used_e),
    .rs2_used_e(rs2_used_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_read_e(mem_read_e), .rd_m(rd_m), .reg_write_m(reg_write_m), .rd_w(rd_w),
    .reg_write_w(reg_write_w), .pc_source(pc_source), .cnt_clr(cnt_clr),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall(stall2), .flush(flush2),
    .stall_count(scnt2), .flush_count(fcnt2));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int          q_cyc[$];
  int          q_inst[$];
  int          q_fld[$];
  logic [15:0] q_val[$];
  string       q_name[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [15:0] actual(input int inst, input int fld);
    logic [1:0]  fa, fb;
    logic        st, fl;
    logic [15:0] sc, fc;
    case (inst)
      0:       begin fa = fwd_a0; fb = fwd_b0; st = stall0; fl = flush0; sc = scnt0; fc = fcnt0; end
      1:       begin fa = fwd_a1; fb = fwd_b1; st = stall1; fl = flush1;
                     sc = {12'd0, scnt1}; fc = {12'd0, fcnt1}; end
      default: begin fa = fwd_a2; fb = fwd_b2; st = stall2; fl = flush2; sc = scnt2; fc = fcnt2; end
    endcase
    case (fld)
      F_FWDA:  return {14'd0, fa};
      F_FWDB:  return {14'd0, fb};
      F_STALL: return {15'd0, st};
      F_FLUSH: return {15'd0, fl};
      F_SCNT:  return sc;
      default: return fc;
    endcase
  endfunction

  always @(negedge CLK) begin
    while (q_cyc.size() != 0 && q_cyc[0] <= cyc) begin
      int          c, inst, fld;
      logic [15:0] exp_v, act_v;
      string       nm;
      c = q_cyc.pop_front();
      inst = q_inst.pop_front();
      fld = q_fld.pop_front();
      exp_v = q_val.pop_front();
      nm = q_name.pop_front();
      act_v = actual(inst, fld);
      checks++;
      if (c != cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never compared", nm, c);
      end else if (act_v !== exp_v) begin
        errors++;
        $display("FAIL %s: inst %0d got %0h expected %0h", nm, inst, act_v, exp_v);
      end
    end
  end

  task automatic expect_v(input int inst, input int fld, input logic [15:0] v,
                          input string nm);
    q_cyc.push_back(cyc);
    q_inst.push_back(inst);
    q_fld.push_back(fld);
    q_val.push_back(v);
    q_name.push_back(nm);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_d = 0; rs2_d = 0; rs1_used_d = 0; rs2_used_d = 0;
    rs1_e = 0; rs2_e = 0; rs1_used_e = 0; rs2_used_e = 0;
    rd_e = 0; reg_write_e = 0; mem_read_e = 0;
    rd_m = 0; reg_write_m = 0; rd_w = 0; reg_write_w = 0;
    pc_source = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    step();
    RST = 1'b0;
  endtask

  // Load-use: load in EX writing x7, ID instruction reads x7 through rs2.
  task automatic apply_load_use();
    mem_read_e = 1; reg_write_e = 1; rd_e = 7; rs2_d = 7; rs2_used_d = 1;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    step();
    // Reset forces outputs low even with a redirect and a forwardable match present.
    pc_source = 3; rs1_e = 5; rs1_used_e = 1; rd_m = 5; reg_write_m = 1;
    expect_v(0, F_FWDA, 0, "rst_fwd_a");
    expect_v(0, F_FLUSH, 0, "rst_flush");
    expect_v(1, F_FLUSH, 0, "rst_flush_l3");
    expect_v(0, F_SCNT, 0, "rst_stall_count");
    expect_v(0, F_FCNT, 0, "rst_flush_count");
    step();

    // Forwarding priority.
    RST = 0;
    clear_inputs();
    rs1_e = 5; rs1_used_e = 1; rd_m = 5; rd_w = 5; reg_write_m = 1; reg_write_w = 1;
    expect_v(0, F_FWDA, 2'b10, "fwd_exmem_priority");
    expect_v(2, F_FWDA, 2'b00, "fwd_off_stall_only");
    step();
    reg_write_m = 0;
    expect_v(0, F_FWDA, 2'b01, "fwd_memwb");
    step();
    rd_m = 0; rd_w = 0;
    expect_v(0, F_FWDA, 2'b00, "fwd_none_x0");
    step();
    // Independent A/B selection.
    rd_m = 5; reg_write_m = 1; rs2_e = 6; rs2_used_e = 1; rd_w = 6; reg_write_w = 1;
    expect_v(0, F_FWDA, 2'b10, "fwd_a_indep");
    expect_v(0, F_FWDB, 2'b01, "fwd_b_indep");
    step();
    clear_inputs();
    rs1_e = 4; rs1_used_e = 0; rd_m = 4; reg_write_m = 1;
    expect_v(0, F_FWDA, 2'b00, "fwd_unused_src");
    step();

    // Load-use at LOAD_LAT=1 (inst 0) and LOAD_LAT=3 (inst 1).
    do_reset();
    apply_load_use();
    expect_v(0, F_STALL, 1, "lu1_stall_c0");
    expect_v(1, F_STALL, 1, "lu3_stall_c0");
    step();
    clear_inputs();
    expect_v(0, F_STALL, 0, "lu1_stall_c1");
    expect_v(0, F_SCNT, 1, "lu1_count_c1");
    expect_v(1, F_STALL, 1, "lu3_stall_c1");
    step();
    expect_v(1, F_STALL, 1, "lu3_stall_c2");
    step();
    expect_v(1, F_STALL, 0, "lu3_stall_c3");
    expect_v(1, F_SCNT, 3, "lu3_count");
    expect_v(0, F_SCNT, 1, "lu1_count_final");
    step();

    // Flush in the second bubble cycle of a LOAD_LAT=3 stall.
    do_reset();
    apply_load_use();
    expect_v(1, F_STALL, 1, "fl_stall_c0");
    step();
    clear_inputs();
    pc_source = 2;
    expect_v(1, F_STALL, 0, "fl_stall_overridden");
    expect_v(1, F_FLUSH, 1, "fl_flush");
    step();
    pc_source = 0;
    expect_v(1, F_STALL, 0, "fl_stall_after");
    expect_v(1, F_FLUSH, 0, "fl_flush_after");
    expect_v(1, F_FCNT, 1, "fl_flush_count");
    expect_v(1, F_SCNT, 1, "fl_stall_count");
    step();

    // x0 destination on a load never stalls.
    clear_inputs();
    mem_read_e = 1; reg_write_e = 1; rd_e = 0; rs1_d = 0; rs1_used_d = 1;
    expect_v(0, F_STALL, 0, "x0_no_stall_l1");
    expect_v(1, F_STALL, 0, "x0_no_stall_l3");
    expect_v(2, F_STALL, 0, "x0_no_stall_nf");
    step();

    // Stall-only mode: MEM match -> 2 cycles, EX match -> 3 cycles.
    do_reset();
    rs1_d = 9; rs1_used_d = 1; rd_m = 9; reg_write_m = 1; rs1_e = 9; rs1_used_e = 1;
    expect_v(2, F_STALL, 1, "nf_mem_stall_c0");
    expect_v(2, F_FWDA, 2'b00, "nf_fwd_a_held");
    expect_v(0, F_FWDA, 2'b10, "fwd_mode_same_inputs");
    expect_v(0, F_STALL, 0, "fwd_mode_no_stall");
    step();
    clear_inputs();
    expect_v(2, F_STALL, 1, "nf_mem_stall_c1");
    step();
    expect_v(2, F_STALL, 0, "nf_mem_stall_c2");
    expect_v(2, F_SCNT, 2, "nf_mem_count");
    step();
    rd_e = 3; reg_write_e = 1; rs2_d = 3; rs2_used_d = 1;
    expect_v(2, F_STALL, 1, "nf_ex_stall_c0");
    step();
    clear_inputs();
    expect_v(2, F_STALL, 1, "nf_ex_stall_c1");
    step();
    expect_v(2, F_STALL, 1, "nf_ex_stall_c2");
    step();
    expect_v(2, F_STALL, 0, "nf_ex_stall_c3");
    expect_v(2, F_SCNT, 5, "nf_total_count");
    step();

    // Saturation: 20 consecutive stall cycles.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      apply_load_use();
      if (i == 19) expect_v(1, F_STALL, 1, "sat_stall_last");
      step();
    end
    clear_inputs();
    expect_v(1, F_SCNT, 15, "sat_count_4bit");
    expect_v(0, F_SCNT, 20, "sat_count_16bit");
    step();
    // cnt_clr in the same cycle as a stall.
    apply_load_use();
    cnt_clr = 1;
    expect_v(1, F_STALL, 1, "clr_stall_same_cycle");
    step();
    clear_inputs();
    expect_v(1, F_SCNT, 0, "clr_priority_l3");
    expect_v(0, F_SCNT, 0, "clr_priority_l1");
    expect_v(1, F_STALL, 1, "mid_stall_before_rst");
    step();
    // Reset mid-stall.
    RST = 1;
    expect_v(1, F_STALL, 0, "rst_forces_stall");
    expect_v(1, F_SCNT, 1, "count_before_rst");
    step();
    RST = 0;
    expect_v(1, F_STALL, 0, "stall_after_rst");
    expect_v(1, F_SCNT, 0, "stall_count_after_rst");
    expect_v(1, F_FCNT, 0, "flush_count_after_rst");
    expect_v(0, F_SCNT, 0, "stall_count_after_rst_l1");
    step();

    step();
    step();
    if (q_cyc.size() != 0) begin
      errors += q_cyc.size();
      checks += q_cyc.size();
      $display("FAIL drain: %0d expectations left, required 0", q_cyc.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
